icache_refill_ctrl: RTL and testbench
=====================================

ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface -- parameters
REQ-001 SHALL have parameter BEATS, default 4: 32-bit words per cache line and AXI burst length.
REQ-002 SHALL have parameter ADDR_W, default 32: address width.

Interface -- ports
REQ-003 SHALL have clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have rstn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have miss_req  input  1  refill request, sampled only in IDLE.
REQ-006 SHALL have miss_addr  input  ADDR_W  missing instruction address.
REQ-007 SHALL have miss_ready  output  1  request accepted this cycle.
REQ-008 SHALL have o_arvalid / i_arready  output/input  1  AXI AR handshake.
REQ-009 SHALL have o_araddr  output  ADDR_W  line-aligned burst address.
REQ-010 SHALL have o_arlen  output  8  constant BEATS-1.
REQ-011 SHALL have o_arsize  output  3  constant 3'b010.
REQ-012 SHALL have o_arburst  output  2  constant INCR (2'b01).
REQ-013 SHALL have i_rvalid / o_rready  input/output  1  AXI R handshake.
REQ-014 SHALL have i_rlast  input  1  AXI last beat.
REQ-015 SHALL have i_rresp  input  2  AXI read response.
REQ-016 SHALL have o_buf_shift  output  1  return-buffer shift enable.
REQ-017 SHALL have o_offset  output  2  latched word offset of the miss within the line.
REQ-018 SHALL have o_refill_done  output  1  one-cycle pulse: line complete and valid.
REQ-019 SHALL have o_refill_err  output  1  one-cycle pulse: refill failed.
REQ-020 SHALL have o_busy  output  1  high whenever state is not IDLE.

Function
REQ-021 SHALL implement FSM states IDLE, AR, R, DONE.
REQ-022 IDLE: miss_req=1 -> miss_ready=1 in the same cycle (combinational); latch araddr = {miss_addr[ADDR_W-1:4],4'b0} and o_offset = miss_addr[3:2]; next state AR.
REQ-023 AR: o_arvalid=1 with o_araddr stable; on i_arready=1 -> R, clear beat counter; o_arvalid SHALL NOT drop before acceptance.
REQ-024 R: o_rready=1; o_buf_shift = i_rvalid & o_rready (combinational, zero latency); each accepted beat increments a clog2(BEATS)-bit counter.
REQ-025 R: an accepted beat with i_rresp != 2'b00 SHALL set a sticky error flag; remaining beats are still drained.
REQ-026 R: an accepted beat with i_rlast=1 -> DONE; a count mismatch (rlast with count != BEATS-1) SHALL set the error flag.
REQ-027 R: an accepted beat at count = BEATS-1 with i_rlast=0 SHALL set the error flag; draining continues until rlast.
REQ-028 DONE: for exactly one cycle, pulse o_refill_done if the error flag is clear, otherwise pulse o_refill_err; then go to IDLE and clear the flag.
REQ-029 SHALL accept no new request outside IDLE; at most one outstanding burst.
REQ-030 o_offset SHALL hold its value from acceptance until the next acceptance.
REQ-031 Minimum latency: miss accepted at cycle 0 with arready=1 and rvalid every cycle -> done pulse in cycle BEATS+2.

Reset
REQ-032 rstn=0 SHALL immediately force state IDLE and zero the counter, error flag, o_araddr and o_offset.
REQ-033 During reset, o_arvalid, o_rready, o_buf_shift, o_refill_done, o_refill_err, o_busy and miss_ready SHALL all be 0.
REQ-034 Reset mid-burst SHALL abandon the burst without any done or err pulse.

Structure
REQ-035 A shared package SHALL hold the state enum and the AXI constants (ARSIZE_4B, ARBURST_INCR, RESP_OKAY).
REQ-036 The block SHALL be a single module without sub-modules.

Verification
REQ-037 Miss at 0x1C00_0038, arready=1, 4 back-to-back OKAY beats with rlast on beat 4 -> araddr 0x1C00_0030, arlen 3, o_offset 2'b10, 4 buf_shift pulses, done pulse in cycle 6.
REQ-038 arready held low for 5 cycles, rvalid gapped 1-in-2 -> arvalid and araddr stable throughout; buf_shift only on valid beats; single done pulse.
REQ-039 Beat 2 has rresp=2'b10 -> all 4 beats drained, o_refill_err pulse, no o_refill_done.
REQ-040 rlast asserted on beat 3 -> err pulse, return to IDLE; with rlast missing on beat 4 and given on beat 5 -> err pulse after beat 5.
REQ-041 rstn low after beat 2 -> all outputs 0 immediately, no pulse; a new miss after reset completes normally.
REQ-042 miss_req held high through a refill -> the second request is accepted only in the cycle after DONE.

Source files
------------

// File: rtl/icache_refill_ctrl_pkg.sv
// rtl/icache_refill_ctrl_pkg.sv - shared state encoding and AXI constants for the icache refill controller
package icache_refill_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] ARSIZE_4B    = 3'b010;
  localparam logic [1:0] ARBURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY    = 2'b00;

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// rtl/icache_refill_ctrl_if.sv - AXI read address/data channel bundle between refill controller and memory
interface icache_refill_ctrl_if #(
  parameter int ADDR_W = 32
);

  logic              o_arvalid;
  logic              i_arready;
  logic [ADDR_W-1:0] o_araddr;
  logic [7:0]        o_arlen;
  logic [2:0]        o_arsize;
  logic [1:0]        o_arburst;
  logic              i_rvalid;
  logic              o_rready;
  logic              i_rlast;
  logic [1:0]        i_rresp;

  // Controller side issues the burst and consumes read beats.
  modport master (
    output o_arvalid, o_araddr, o_arlen, o_arsize, o_arburst, o_rready,
    input  i_arready, i_rvalid, i_rlast, i_rresp
  );

  // Memory side accepts the burst and returns read beats.
  modport slave (
    input  o_arvalid, o_araddr, o_arlen, o_arsize, o_arburst, o_rready,
    output i_arready, i_rvalid, i_rlast, i_rresp
  );

endinterface

// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - single-burst instruction cache line refill controller
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int BEATS  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    miss_req,
  input  logic [ADDR_W-1:0]       miss_addr,
  output logic                    miss_ready,
  icache_refill_ctrl_if.master    axi,
  output logic                    o_buf_shift,
  output logic [1:0]              o_offset,
  output logic                    o_refill_done,
  output logic                    o_refill_err,
  output logic                    o_busy
);

  localparam int              CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [ADDR_W-1:0]  araddr_q, araddr_d;
  logic [1:0]         off_q, off_d;
  logic               beat_acc;
  logic               arvalid;
  logic               rready;
  logic               unused_addr_lsb;

  // Byte-within-word bits never matter for a word-granular line fill.
  assign unused_addr_lsb = ^miss_addr[1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      araddr_q <= '0;
      off_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      araddr_q <= araddr_d;
      off_q    <= off_d;
    end
  end

  assign beat_acc = axi.i_rvalid & rready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    araddr_d      = araddr_q;
    off_d         = off_q;
    miss_ready    = 1'b0;
    arvalid       = 1'b0;
    rready        = 1'b0;
    o_refill_done = 1'b0;
    o_refill_err  = 1'b0;

    case (state_q)
      IDLE: begin
        // rstn gates the accept so nothing is acknowledged while reset is held.
        if (miss_req && rstn) begin
          miss_ready = 1'b1;
          araddr_d   = {miss_addr[ADDR_W-1:4], 4'b0000};
          off_d      = miss_addr[3:2];
          state_d    = AR;
        end
      end

      AR: begin
        arvalid = 1'b1;
        if (axi.i_arready) begin
          cnt_d   = '0;
          state_d = R;
        end
      end

      R: begin
        rready = 1'b1;
        if (beat_acc) begin
          cnt_d = cnt_q + 1'b1;
          if (axi.i_rresp != RESP_OKAY) begin
            err_d = 1'b1;
          end
          // A short or long burst both poison the line; keep draining until rlast.
          if (axi.i_rlast) begin
            state_d = DONE;
            if (cnt_q != LAST_CNT) begin
              err_d = 1'b1;
            end
          end else if (cnt_q == LAST_CNT) begin
            err_d = 1'b1;
          end
        end
      end

      DONE: begin
        o_refill_done = ~err_q;
        o_refill_err  = err_q;
        err_d         = 1'b0;
        state_d       = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign axi.o_arvalid = arvalid;
  assign axi.o_araddr  = araddr_q;
  assign axi.o_arlen   = 8'(BEATS - 1);
  assign axi.o_arsize  = ARSIZE_4B;
  assign axi.o_arburst = ARBURST_INCR;
  assign axi.o_rready  = rready;

  assign o_buf_shift = beat_acc;
  assign o_offset    = off_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - randomized scoreboard bench for the icache refill controller
module tb_icache_refill_ctrl;

  localparam int BEATS  = 4;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              miss_req = 1'b0;
  logic [ADDR_W-1:0] miss_addr = '0;
  logic              miss_ready;
  logic              o_buf_shift;
  logic [1:0]        o_offset;
  logic              o_refill_done;
  logic              o_refill_err;
  logic              o_busy;

  always #5 clk = ~clk;

  icache_refill_ctrl_if #(.ADDR_W(ADDR_W)) axi ();

  icache_refill_ctrl #(.BEATS(BEATS), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .miss_req     (miss_req),
    .miss_addr    (miss_addr),
    .miss_ready   (miss_ready),
    .axi          (axi),
    .o_buf_shift  (o_buf_shift),
    .o_offset     (o_offset),
    .o_refill_done(o_refill_done),
    .o_refill_err (o_refill_err),
    .o_busy       (o_busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  off;
    bit          err;
    int          shifts;
    int          lat;
    bit          b2b;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          active = 0;
  int          acc_cyc = 0;
  int          last_done = -100;
  int          shifts = 0;
  int          gap[16];
  logic [1:0]  resp[16];
  bit          next_b2b = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event not seen / not allowed (cycle %0d)", name, cyc);
  endtask

  // Monitor: samples on the falling edge, pops expectations at each accept.
  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      chk("reset_ctrl_outs", {miss_ready, axi.o_arvalid, axi.o_rready, o_buf_shift,
                              o_refill_done, o_refill_err, o_busy}, 0);
      chk("reset_araddr_offset", {axi.o_araddr, o_offset}, 0);
      active = 0;
      shifts = 0;
    end else begin
      if (miss_ready) begin
        chk("accept_only_idle", o_busy, 0);
        if (exp_q.size() == 0) begin
          fail("unexpected_accept");
        end else begin
          cur     = exp_q.pop_front();
          active  = 1;
          acc_cyc = cyc;
          shifts  = 0;
          if (cur.b2b) chk("b2b_accept_cycle", acc_cyc, last_done + 1);
        end
      end
      if (axi.o_arvalid && active) begin
        chk("araddr", axi.o_araddr, cur.addr);
        chk("ar_len_size_burst", {axi.o_arlen, axi.o_arsize, axi.o_arburst},
            {8'(BEATS - 1), 3'b010, 2'b01});
      end
      if (o_buf_shift) begin
        shifts++;
        chk("buf_shift_on_valid", axi.i_rvalid, 1);
      end
      if (o_refill_done || o_refill_err) begin
        if (!active) begin
          fail("unexpected_pulse");
        end else begin
          chk("done_err", {o_refill_done, o_refill_err}, {!cur.err, cur.err});
          chk("shift_count", shifts, cur.shifts);
          chk("offset", o_offset, cur.off);
          chk("latency", cyc - acc_cyc, cur.lat);
        end
        last_done = cyc;
        active    = 0;
      end
    end
  end

  task automatic set_clean(input int g);
    for (int i = 0; i < 16; i++) begin
      gap[i]  = g;
      resp[i] = 2'b00;
    end
  endtask

  // Memory-side driver for one refill; abort_after>0 pulls reset after that many beats.
  task automatic run_txn(input logic [31:0] addr, input int nb, input int ard,
                         input bit hold, input int abort_after);
    exp_t e;
    int   lat;
    bit   bad;
    int   t;
    int   cnt;
    bad = 0;
    lat = 2 + ard;
    for (int i = 0; i < nb; i++) begin
      lat += gap[i] + 1;
      if (resp[i] != 2'b00) bad = 1;
    end
    e.addr   = {addr[31:4], 4'b0000};
    e.off    = addr[3:2];
    e.err    = bad || (nb != BEATS);
    e.shifts = nb;
    e.lat    = lat;
    e.b2b    = next_b2b;
    next_b2b = hold;
    exp_q.push_back(e);

    miss_addr     = addr;
    miss_req      = 1'b1;
    axi.i_arready = (ard == 0);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!miss_ready && t < 60);
    if (!miss_ready) begin
      fail("accept_timeout");
      miss_req = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (!hold) miss_req = 1'b0;
    miss_addr = $urandom;

    cnt = 0;
    t   = 0;
    forever begin
      @(negedge clk);
      t++;
      if (axi.o_arvalid && axi.i_arready) break;
      if (axi.o_arvalid) cnt++;
      if (t > 100) begin
        fail("ar_timeout");
        return;
      end
      @(posedge clk);
      #1;
      if (cnt >= ard) axi.i_arready = 1'b1;
    end
    @(posedge clk);
    #1;
    axi.i_arready = 1'b0;

    for (int i = 0; i < nb; i++) begin
      repeat (gap[i]) begin
        axi.i_rvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      axi.i_rvalid = 1'b1;
      axi.i_rresp  = resp[i];
      axi.i_rlast  = (i == nb - 1);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!axi.o_rready && t < 20);
      if (!axi.o_rready) fail("rready_timeout");
      @(posedge clk);
      #1;
      if (i + 1 == abort_after) begin
        axi.i_rvalid = 1'b0;
        axi.i_rlast  = 1'b0;
        axi.i_rresp  = 2'b00;
        rstn         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        return;
      end
    end
    axi.i_rvalid = 1'b0;
    axi.i_rlast  = 1'b0;
    axi.i_rresp  = 2'b00;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (o_busy && t < 100);
    if (o_busy) fail("idle_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int  nb;
    int  ard;
    int  r;
    bit  hold;
    axi.i_arready = 1'b0;
    axi.i_rvalid  = 1'b0;
    axi.i_rlast   = 1'b0;
    axi.i_rresp   = 2'b00;
    miss_req      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    miss_req = 1'b0;
    rstn     = 1'b1;
    @(posedge clk);
    #1;

    // Minimum-latency line fill with the documented example address.
    set_clean(0);
    run_txn(32'h1C00_0038, 4, 0, 0, -1);
    wait_idle();
    // Slow address acceptance and 1-in-2 data gaps.
    set_clean(1);
    run_txn($urandom, 4, 5, 0, -1);
    wait_idle();
    // Slave error on beat 2.
    set_clean(0);
    resp[1] = 2'b10;
    run_txn($urandom, 4, 0, 0, -1);
    wait_idle();
    // Early and late rlast.
    set_clean(0);
    run_txn($urandom, 3, 0, 0, -1);
    wait_idle();
    run_txn($urandom, 5, 1, 0, -1);
    wait_idle();
    // Reset after beat 2, then a clean refill.
    run_txn($urandom, 4, 0, 0, 2);
    run_txn($urandom, 4, 0, 0, -1);
    wait_idle();
    // Request held high across a refill.
    run_txn($urandom, 4, 0, 1, -1);
    run_txn($urandom, 4, 0, 0, -1);
    wait_idle();

    for (int k = 0; k < 40; k++) begin
      r  = $urandom_range(0, 9);
      nb = (r == 0) ? BEATS - 1 : (r == 1) ? BEATS + 1 : BEATS;
      ard = $urandom_range(0, 4);
      set_clean(0);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) gap[i] = $urandom_range(0, 2);
      end
      if ($urandom_range(0, 3) == 0) resp[$urandom_range(0, nb - 1)] = 2'($urandom_range(1, 3));
      hold = (k != 39) && ($urandom_range(0, 4) == 0);
      run_txn($urandom, nb, ard, hold, -1);
      if (!hold) wait_idle();
    end

    wait_idle();
    chk("scoreboard_drained", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
